// File: rtl/salu_seq_pkg.sv
// salu_seq_pkg: shared types and instruction layout for the salu_seq command sequencer.
// Contents: FSM state enum, opcode width/limit, instruction field positions, CMD_W.
// Build option SALU_SEQ_IMM_EN widens instructions to 24 bits with an 8-bit immediate.
package salu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int               OP_W   = 4;
  localparam logic [OP_W-1:0]  OP_MAX = 4'hB;
  localparam int               RA_W   = 2;   // register address width (4 entries)

  // Instruction field LSB positions
  localparam int OP_LSB   = 12;
  localparam int DST_LSB  = 10;
  localparam int SRCA_LSB = 8;
  localparam int SRCB_LSB = 6;

`ifdef SALU_SEQ_IMM_EN
  localparam int CMD_W       = 24;
  localparam int USE_IMM_BIT = 5;
  localparam int IMM_LSB     = 16;
  localparam int IMM_W       = 8;
`else
  localparam int CMD_W       = 16;
`endif

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return op <= OP_MAX;
  endfunction

endpackage

// File: rtl/salu_seq_if.sv
// salu_seq_if: host-side command/response handshakes of salu_seq.
// Signals: cmd_valid/cmd_ready/cmd_data (instruction in), rsp_valid/rsp_ready/rsp_data/rsp_err (result out).
// master = host side, slave = sequencer side. CMD_W follows SALU_SEQ_IMM_EN via the package.
interface salu_seq_if
  import salu_seq_pkg::*;
#(
  parameter int DW = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CMD_W-1:0] cmd_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [DW-1:0]    rsp_data;
  logic             rsp_err;

  modport master (
    output cmd_valid, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/salu_seq_regfile.sv
// salu_seq_regfile: NREG x DW register file, two combinational read ports, two synchronous write ports.
// Ports: clk, rst (sync, active high), ra/rb read ports, host write port, writeback write port.
// A writeback and a host write to the same address in one cycle: the writeback is kept.
module salu_seq_regfile
  import salu_seq_pkg::*;
#(
  parameter int DW   = 8,
  parameter int NREG = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] ra_addr_i,
  output logic [DW-1:0]   ra_data_o,
  input  logic [RA_W-1:0] rb_addr_i,
  output logic [DW-1:0]   rb_data_o,
  input  logic            host_we_i,
  input  logic [RA_W-1:0] host_addr_i,
  input  logic [DW-1:0]   host_data_i,
  input  logic            wb_we_i,
  input  logic [RA_W-1:0] wb_addr_i,
  input  logic [DW-1:0]   wb_data_i
);
  logic [DW-1:0] regs_q [NREG];

  assign ra_data_o = regs_q[ra_addr_i];
  assign rb_data_o = regs_q[rb_addr_i];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (rst) begin
        regs_q[i] <= '0;
      end else if (wb_we_i && (wb_addr_i == RA_W'(i))) begin
        regs_q[i] <= wb_data_i;
      end else if (host_we_i && (host_addr_i == RA_W'(i))) begin
        regs_q[i] <= host_data_i;
      end
    end
  end
endmodule

// File: rtl/salu_seq.sv
// salu_seq: issues one host instruction at a time to an external salu and returns its result.
// Ports: clk/rst, host (cmd/rsp handshakes), wr_* host register write, operanda/operandb/mux to salu, result from salu.
// Legal op: response two cycles after acceptance; illegal op: one cycle. SALU_SEQ_IMM_EN enables the immediate operand.
module salu_seq
  import salu_seq_pkg::*;
#(
  parameter int DW   = 8,
  parameter int NREG = 4
) (
  input  logic            clk,
  input  logic            rst,
  salu_seq_if.slave       host,
  input  logic            wr_en,
  input  logic [RA_W-1:0] wr_addr,
  input  logic [DW-1:0]   wr_data,
  output logic [DW-1:0]   operanda,
  output logic [DW-1:0]   operandb,
  output logic [OP_W-1:0] mux,
  input  logic [DW-1:0]   result
);
  state_e          state_q, state_d;
  logic [DW-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic [OP_W-1:0] mux_q, mux_d;
  logic [RA_W-1:0] dst_q, dst_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic            wb_we;

  logic [OP_W-1:0] cmd_op;
  logic [RA_W-1:0] cmd_dst, cmd_srca, cmd_srcb;
  logic [DW-1:0]   rd_a, rd_b, opb_sel;

  assign cmd_op   = host.cmd_data[OP_LSB   +: OP_W];
  assign cmd_dst  = host.cmd_data[DST_LSB  +: RA_W];
  assign cmd_srca = host.cmd_data[SRCA_LSB +: RA_W];
  assign cmd_srcb = host.cmd_data[SRCB_LSB +: RA_W];

`ifdef SALU_SEQ_IMM_EN
  logic [4:0] unused_cmd_bits;
  assign unused_cmd_bits = host.cmd_data[4:0];
  assign opb_sel = host.cmd_data[USE_IMM_BIT] ? DW'(host.cmd_data[IMM_LSB +: IMM_W]) : rd_b;
`else
  logic [5:0] unused_cmd_bits;
  assign unused_cmd_bits = host.cmd_data[5:0];
  assign opb_sel = rd_b;
`endif

  salu_seq_regfile #(.DW(DW), .NREG(NREG)) u_rf (
    .clk         (clk),
    .rst         (rst),
    .ra_addr_i   (cmd_srca),
    .ra_data_o   (rd_a),
    .rb_addr_i   (cmd_srcb),
    .rb_data_o   (rd_b),
    .host_we_i   (wr_en),
    .host_addr_i (wr_addr),
    .host_data_i (wr_data),
    .wb_we_i     (wb_we),
    .wb_addr_i   (dst_q),
    .wb_data_i   (result)
  );

  // Handshake outputs are masked while rst is high so nothing is offered or accepted during reset.
  assign host.cmd_ready = (state_q == ST_IDLE) && !rst;
  assign host.rsp_valid = (state_q == ST_RESP) && !rst;
  assign host.rsp_data  = rsp_data_q;
  assign host.rsp_err   = rsp_err_q;
  assign operanda       = opa_q;
  assign operandb       = opb_q;
  assign mux            = mux_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      opa_q      <= '0;
      opb_q      <= '0;
      mux_q      <= '0;
      dst_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      mux_q      <= mux_d;
      dst_q      <= dst_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    mux_d      = mux_q;
    dst_d      = dst_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    wb_we      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (host.cmd_valid) begin
          if (op_legal(cmd_op)) begin
            // Operands see the register file before any host write landing this edge.
            opa_d   = rd_a;
            opb_d   = opb_sel;
            mux_d   = cmd_op;
            dst_d   = cmd_dst;
            state_d = ST_EXEC;
          end else begin
            // salu interface is left untouched for a rejected opcode.
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            state_d    = ST_RESP;
          end
        end
      end
      ST_EXEC: begin
        // salu has had the whole cycle to settle on the registered operands.
        rsp_data_d = result;
        rsp_err_d  = 1'b0;
        wb_we      = 1'b1;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (host.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_salu_seq.sv
module tb_salu_seq;
  import salu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] operanda, operandb, result;
  logic [3:0] mux;

  always #5 clk = ~clk;

  salu_seq_if #(.DW(8)) bus ();

  salu_seq #(.DW(8), .NREG(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .host     (bus.slave),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .operanda (operanda),
    .operandb (operandb),
    .mux      (mux),
    .result   (result)
  );

  // Stand-in salu: a fixed table of 12 operations.
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return ~(a & b);
      4'h6: return ~(a | b);
      4'h7: return ~(a ^ b);
      4'h8: return ~a;
      4'h9: return a;
      4'hA: return b;
      4'hB: return a << 1;
      default: return 8'h00;
    endcase
  endfunction

  always_comb result = alu_f(operanda, operandb, mux);

  // Expected observable state
  logic [7:0] m_rf [4];
  logic [7:0] m_opa, m_opb, m_data;
  logic [3:0] m_mux;
  logic       m_rdy, m_vld, m_err, m_dz;
  bit         chk_en = 1'b0;
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] rv;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%02h required=0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_ready", 8'(bus.cmd_ready), 8'(m_rdy));
      chk("rsp_valid", 8'(bus.rsp_valid), 8'(m_vld));
      chk("operanda", operanda, m_opa);
      chk("operandb", operandb, m_opb);
      chk("mux", 8'(mux), 8'(m_mux));
      if (m_vld || m_dz) begin
        chk("rsp_data", bus.rsp_data, m_vld ? m_data : 8'h00);
        chk("rsp_err", 8'(bus.rsp_err), m_vld ? 8'(m_err) : 8'h00);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
    m_opa = 8'h00; m_opb = 8'h00; m_mux = 4'h0;
    m_vld = 1'b0; m_err = 1'b0; m_data = 8'h00; m_dz = 1'b1;
  endtask

  function automatic logic [CMD_W-1:0] mk_cmd(input logic [3:0] op, input logic [1:0] d, input logic [1:0] a,
                                               input logic [1:0] b, input logic ui, input logic [7:0] imm);
    logic [CMD_W-1:0] c;
    c = '0;
    c[15:12] = op;
    c[11:10] = d;
    c[9:8]   = a;
    c[7:6]   = b;
    c[5]     = ui;
    // Reserved bits carry junk; the sequencer must ignore them.
    c[4:0]   = imm[4:0] ^ {2'b00, imm[7:5]};
`ifdef SALU_SEQ_IMM_EN
    c[23:16] = imm;
`endif
    return c;
  endfunction

  task automatic host_wr(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    m_rf[a] = d;
  endtask

  // hw_ph: 0 no host write, 1 host write in the acceptance cycle, 2 host write in the execute cycle.
  task automatic run_cmd(input logic [3:0] op, input logic [1:0] d, input logic [1:0] a, input logic [1:0] b,
                         input logic ui, input logic [7:0] imm, input int hw_ph, input logic [1:0] hw_a,
                         input logic [7:0] hw_d, input int dly, output logic [7:0] rdata);
    logic [7:0] na, nb, r;
    logic       legal;
    legal = (op <= 4'hB);
    na = m_rf[a];
`ifdef SALU_SEQ_IMM_EN
    nb = ui ? imm : m_rf[b];
`else
    nb = m_rf[b];
`endif
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = mk_cmd(op, d, a, b, ui, imm);
    if (hw_ph == 1) begin wr_en = 1'b1; wr_addr = hw_a; wr_data = hw_d; end
    tick();
    bus.cmd_valid = 1'b0;
    wr_en = 1'b0;
    if (hw_ph == 1) m_rf[hw_a] = hw_d;
    m_rdy = 1'b0;
    m_dz  = 1'b0;
    if (legal) begin
      m_opa = na; m_opb = nb; m_mux = op;
      r = alu_f(na, nb, op);
      if (hw_ph == 2) begin wr_en = 1'b1; wr_addr = hw_a; wr_data = hw_d; end
      tick();
      wr_en = 1'b0;
      if (hw_ph == 2) m_rf[hw_a] = hw_d;
      m_rf[d] = r;
      m_vld = 1'b1; m_data = r; m_err = 1'b0;
    end else begin
      m_vld = 1'b1; m_data = 8'h00; m_err = 1'b1;
    end
    for (int k = 0; k < dly; k++) tick();
    bus.rsp_ready = 1'b1;
    #3 rdata = bus.rsp_data;
    tick();
    bus.rsp_ready = 1'b0;
    m_vld = 1'b0;
    m_rdy = 1'b1;
  endtask

  // Read a register with op 9 (pass a) written back onto itself.
  task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string name);
    logic [7:0] v;
    run_cmd(4'h9, a, a, a, 1'b0, 8'h00, 0, 2'd0, 8'h00, 0, v);
    chk(name, v, exp);
  endtask

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_data = '0; bus.rsp_ready = 1'b0;
    wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'h00;
    model_reset();
    m_rdy = 1'b0;
    tick();
    chk_en = 1'b1;
    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      bus.cmd_valid = 1'($urandom);
      bus.cmd_data  = CMD_W'($urandom);
      bus.rsp_ready = 1'($urandom);
      wr_en   = 1'($urandom);
      wr_addr = 2'($urandom);
      wr_data = 8'($urandom);
      tick();
    end
    bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b0; wr_en = 1'b0;
    rst = 1'b0;
    m_rdy = 1'b1;
    tick();

    // Basic AND: 0x6A & 0x3B = 0x2A into r2
    host_wr(2'd0, 8'h6A);
    host_wr(2'd1, 8'h3B);
    run_cmd(4'h2, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 0, 2'd0, 8'h00, 0, rv);
    chk("and_lit", rv, 8'h2A);
    rd(2'd2, 8'h2A, "r2_wb");

    // Sweep all legal ops back to back
    for (int op = 0; op < 12; op++) begin
      run_cmd(4'(op), 2'd3, 2'd0, 2'd1, 1'b0, 8'h00, 0, 2'd0, 8'h00, 0, rv);
      if (op == 0) chk("add_lit", rv, 8'hA5);
      if (op == 1) chk("sub_lit", rv, 8'h2F);
    end

    // Illegal opcode: error response, nothing modified
    run_cmd(4'hD, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00, 0, 2'd0, 8'h00, 0, rv);
    chk("illegal_data", rv, 8'h00);
    rd(2'd0, 8'h6A, "illegal_no_wr");

    // Writeback vs host write collisions
    run_cmd(4'h0, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 2, 2'd2, 8'hFF, 0, rv);
    rd(2'd2, 8'hA5, "wb_wins");
    run_cmd(4'h1, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 2, 2'd3, 8'h55, 0, rv);
    rd(2'd3, 8'h55, "host_other_addr");
    rd(2'd2, 8'h2F, "wb_other_addr");

    // Host write during acceptance: operand sees old value
    run_cmd(4'h9, 2'd3, 2'd0, 2'd1, 1'b0, 8'h00, 1, 2'd0, 8'h11, 0, rv);
    chk("no_bypass", rv, 8'h6A);
    rd(2'd0, 8'h11, "accept_wr_lands");

    // Response held under backpressure
    run_cmd(4'h4, 2'd3, 2'd0, 2'd1, 1'b0, 8'h00, 0, 2'd0, 8'h00, 3, rv);
    chk("xor_lit", rv, 8'h2A);

    // Immediate operand (or ignored bit 5 in the default build)
    host_wr(2'd1, 8'hC4);
    run_cmd(4'hA, 2'd3, 2'd0, 2'd1, 1'b1, 8'h3B, 0, 2'd0, 8'h00, 0, rv);
`ifdef SALU_SEQ_IMM_EN
    chk("imm_opb", rv, 8'h3B);
`else
    chk("bit5_ignored", rv, 8'hC4);
`endif

    // Reset during execute: no response, no writeback
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = mk_cmd(4'h0, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00);
    tick();
    bus.cmd_valid = 1'b0;
    m_rdy = 1'b0; m_dz = 1'b0;
    m_opa = m_rf[0]; m_opb = m_rf[1]; m_mux = 4'h0;
    rst = 1'b1;
    tick();
    model_reset();
    rst = 1'b0;
    m_rdy = 1'b1;
    tick();
    rd(2'd2, 8'h00, "rst_no_wb");

    tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/salu_seq.md
# salu_seq

Command sequencer that drives the `salu` combinational ALU, acting as its issuing side rather than its consumer. A host hands it one instruction at a time over a valid/ready handshake. The block then:
- reads two operands from a 4-entry, 8-bit register file,
- drives `operanda`/`operandb`/`mux` to an external `salu` instance,
- samples `result` and writes it back,
- returns the result to the host over a second valid/ready handshake.

It sits between the host/test controller and `salu`.

## Interface
Parameters:
- DW, 8, datapath width; must equal the `salu` operand width
- NREG, 4, register-file depth; fixed to 4 by the 2-bit register fields

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  instruction offered
- cmd_ready  out  1  block can accept an instruction
- cmd_data  in  CMD_W  instruction: [15:12] op, [11:10] dst, [9:8] srca, [7:6] srcb, [5:0] reserved; CMD_W=16, or 24 under SALU_SEQ_IMM_EN
- wr_en  in  1  host register write
- wr_addr  in  2  host write address
- wr_data  in  DW  host write data
- operanda  out  DW  to `salu` operanda
- operandb  out  DW  to `salu` operandb
- mux  out  4  to `salu` mux
- result  in  DW  from `salu` result
- rsp_valid  out  1  response available
- rsp_ready  in  1  host accepts response
- rsp_data  out  DW  captured ALU result
- rsp_err  out  1  illegal opcode flag

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid with a legal op (0x0–0xB):
    - latch operanda=reg[srca], operandb=reg[srcb], mux=op, and dst;
    - go to EXEC.
  - On cmd_valid with an illegal op (0xC–0xF):
    - rsp_err=1, rsp_data=0;
    - operanda/operandb/mux keep their previous values;
    - go to RESP.
- EXEC (exactly one cycle):
  - `salu` settles combinationally.
  - At the end of the cycle: rsp_data←result, reg[dst]←result, rsp_err=0; go to RESP.
- RESP:
  - rsp_valid=1.
  - rsp_data/rsp_err stay stable until rsp_valid && rsp_ready, then go to IDLE.
  - cmd_ready=0 in EXEC and RESP.
- operanda/operandb/mux hold their last-issued values outside EXEC.
- Register file:
  - combinational read, synchronous write;
  - two write sources: host (wr_en) and writeback (EXEC end).
- Simultaneous write:
  - same address: writeback wins, host write dropped;
  - different addresses: both written.
- Host write in the same cycle as acceptance: operands read the pre-write value (no bypass).
- Host writes are permitted in any state.
- No arithmetic in this block. All `salu` behaviour is external.

## Timing
- Reset values:
  - state=IDLE, all registers 0;
  - operanda=operandb=0, mux=0;
  - rsp_valid=0, rsp_data=0, rsp_err=0;
  - cmd_ready=0 while rst is high, 1 in the first cycle after.
- Legal op: acceptance edge T → operands driven from T+1 → rsp_valid high from T+2. Write-back is visible to a command accepted at T+3 or later.
- Illegal op: rsp_valid high from T+1.
- Back-to-back throughput is one instruction per 3 cycles when rsp_ready is held high.
- rsp_ready high in the same cycle rsp_valid rises completes the response at that edge.
- rst asserted mid-operation:
  - the operation is abandoned;
  - no write-back and no response;
  - all reset values apply at the next edge.

## Configuration
- SALU_SEQ_IMM_EN defined:
  - CMD_W=24, with cmd_data[23:16]=imm and cmd_data[5]=use_imm;
  - use_imm=1 selects operandb=imm in place of reg[srcb].
- Undefined:
  - CMD_W=16, bit 5 is reserved and ignored;
  - operandb always comes from reg[srcb].

## Structure
- Package `salu_seq_pkg`:
  - state enum, OP_W=4, OP_MAX=4'hB;
  - instruction field positions;
  - CMD_W selection under the macro.
- Sub-module `salu_seq_regfile`:
  - 4×DW registers;
  - two async read ports, host write port, writeback write port;
  - writeback-priority rule lives here.

## Test plan
- Reset with random inputs → all outputs 0, cmd_ready=0 while rst=1 and 1 the cycle after.
- Load r0=0x6A, r1=0x3B; issue op=0x2, srca=0, srcb=1, dst=2 at T:
  - operanda=0x6A, operandb=0x3B, mux=2 from T+1;
  - rsp_valid at T+2 with rsp_data=`salu` result;
  - r2 updated.
- Sweep op 0x0–0xB on the same operands with a real `salu` attached → each rsp_data matches the model, rsp_err=0.
- Issue op=0xD:
  - rsp_valid at T+1 with rsp_err=1, rsp_data=0;
  - mux unchanged, no register modified.
- Host write to r2=0xFF in the same cycle as writeback to r2 → r2 holds the ALU result. A host write to r3 in that cycle also lands.
- Assert rst during EXEC → no rsp_valid, dst register reads 0. With SALU_SEQ_IMM_EN, use_imm=1, imm=0x3B → operandb=0x3B regardless of reg[srcb].
